spi_mstr_param: RTL and testbench

SPI_MSTR_PARAM -- requirements
Module: spi_mstr_param

---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_sclk_gen.sv | 53 +++++
 rtl/spi_mstr_param.sv | 166 ++++++++++++++++
 tb/tb_spi_mstr_param.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and default sizing for the parameterised SPI master.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FRONT = 2'b01,
        ST_SHIFT = 2'b10
    } spi_state_e;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_DIV_W  = 5;
    localparam int DEF_NUM_SS = 2;

    // Width of the slave index; a single-slave build still needs one bit.
    function automatic int sel_width(input int num_ss);
        if (num_ss > 1) begin
            return $clog2(num_ss);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider: free-running counter while a transfer is active, with
// single-cycle fall/rise strobes decoded from the counter value.
module spi_sclk_gen #(
    parameter int DIV_W = 5
) (
    input  logic clk,
    input  logic rst_cnt,
    input  logic load,
    input  logic run,
    input  logic run_nxt,
    output logic SCLK,
    output logic fall,
    output logic rise
);

    // Load value places the first fall a quarter period after the start.
    localparam logic [DIV_W-1:0] DIV_LOAD = {2'b10, {(DIV_W-2){1'b1}}};
    localparam logic [DIV_W-1:0] DIV_FALL = {DIV_W{1'b1}};
    localparam logic [DIV_W-1:0] DIV_RISE = {1'b0, {(DIV_W-1){1'b1}}};
    localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] div_nxt_s;
    logic             sclk_r;

    // Next divider value.
    always_comb begin
        div_nxt_s = div_r;
        if (load) begin
            div_nxt_s = DIV_LOAD;
        end else if (run) begin
            div_nxt_s = div_r + DIV_ONE;
        end else begin
            div_nxt_s = div_r;
        end
    end

    // Divider and glitch-free registered SCLK (high whenever idle).
    always_ff @(posedge clk or posedge rst_cnt) begin
        if (rst_cnt) begin
            div_r  <= {DIV_W{1'b0}};
            sclk_r <= 1'b1;
        end else begin
            div_r  <= div_nxt_s;
            sclk_r <= run_nxt ? div_nxt_s[DIV_W-1] : 1'b1;
        end
    end

    assign SCLK = sclk_r;
    assign fall = run && (div_r == DIV_FALL);
    assign rise = run && (div_r == DIV_RISE);

endmodule

// File: rtl/spi_mstr_param.sv
// Parameterised SPI master (mode 3 style: SCLK idles high, MOSI changes on
// falling SCLK, MISO sampled on rising SCLK).
module spi_mstr_param
    import spi_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DIV_W     = DEF_DIV_W,
    parameter int NUM_SS    = DEF_NUM_SS,
    parameter int MSB_FIRST = 1
) (
    input  logic                          clk,
    input  logic                          rst_cnt,
    input  logic                          wrt,
    input  logic [DATA_W-1:0]             cmd,
    input  logic [sel_width(NUM_SS)-1:0]  ss_sel,
    input  logic                          MISO,
    output logic [NUM_SS-1:0]             SS_n,
    output logic                          SCLK,
    output logic                          MOSI,
    output logic                          busy,
    output logic                          done,
    output logic [DATA_W-1:0]             rd_data
);

    localparam int               CNT_W    = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    spi_state_e        state_r, state_nxt_s;
    logic [DATA_W-1:0] sr_r, sr_nxt_s, sr_shift_s;
    logic              buf_r, buf_nxt_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
    logic [NUM_SS-1:0] ss_n_r, ss_n_nxt_s;
    logic              busy_r, busy_nxt_s;
    logic              done_r, done_nxt_s;
    logic [DATA_W-1:0] rd_r, rd_nxt_s;
    logic              accept_s;
    logic              fall_s;
    logic              rise_s;

    spi_sclk_gen #(
        .DIV_W (DIV_W)
    ) u_sclk_gen (
        .clk     (clk),
        .rst_cnt (rst_cnt),
        .load    (accept_s),
        .run     (state_r != ST_IDLE),
        .run_nxt (state_nxt_s != ST_IDLE),
        .SCLK    (SCLK),
        .fall    (fall_s),
        .rise    (rise_s)
    );

    // Shift register with the sampled MISO bit entering at the far end.
    always_comb begin
        sr_shift_s = sr_r;
        if (MSB_FIRST != 0) begin
            sr_shift_s = {sr_r[DATA_W-2:0], buf_r};
        end else begin
            sr_shift_s = {buf_r, sr_r[DATA_W-1:1]};
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt_s = state_r;
        sr_nxt_s    = sr_r;
        buf_nxt_s   = buf_r;
        cnt_nxt_s   = cnt_r;
        ss_n_nxt_s  = ss_n_r;
        busy_nxt_s  = busy_r;
        done_nxt_s  = done_r;
        rd_nxt_s    = rd_r;
        accept_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (wrt) begin
                    accept_s    = 1'b1;
                    sr_nxt_s    = cmd;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    done_nxt_s  = 1'b0;
                    busy_nxt_s  = 1'b1;
                    state_nxt_s = ST_FRONT;
                    // An out-of-range index leaves every select high.
                    for (int i = 0; i < NUM_SS; i++) begin
                        if (int'(ss_sel) == i) begin
                            ss_n_nxt_s[i] = 1'b0;
                        end else begin
                            ss_n_nxt_s[i] = 1'b1;
                        end
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FRONT: begin
                if (fall_s) begin
                    state_nxt_s = ST_SHIFT;
                end else begin
                    state_nxt_s = ST_FRONT;
                end
            end
            ST_SHIFT: begin
                if (rise_s) begin
                    buf_nxt_s = MISO;
                    if (cnt_r != CNT_LAST) begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end else begin
                        cnt_nxt_s = cnt_r;
                    end
                end else begin
                    buf_nxt_s = buf_r;
                end
                if (fall_s) begin
                    sr_nxt_s = sr_shift_s;
                    if (cnt_r == CNT_LAST) begin
                        rd_nxt_s    = sr_shift_s;
                        ss_n_nxt_s  = {NUM_SS{1'b1}};
                        done_nxt_s  = 1'b1;
                        busy_nxt_s  = 1'b0;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_SHIFT;
                    end
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            default: begin
                ss_n_nxt_s  = {NUM_SS{1'b1}};
                busy_nxt_s  = 1'b0;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst_cnt) begin
        if (rst_cnt) begin
            state_r <= ST_IDLE;
            sr_r    <= {DATA_W{1'b0}};
            buf_r   <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
            ss_n_r  <= {NUM_SS{1'b1}};
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            rd_r    <= {DATA_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            sr_r    <= sr_nxt_s;
            buf_r   <= buf_nxt_s;
            cnt_r   <= cnt_nxt_s;
            ss_n_r  <= ss_n_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
            rd_r    <= rd_nxt_s;
        end
    end

    assign MOSI    = (MSB_FIRST != 0) ? sr_r[DATA_W-1] : sr_r[0];
    assign SS_n    = ss_n_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign rd_data = rd_r;

endmodule

// File: tb/tb_spi_mstr_param.sv
// Directed bench for spi_mstr_param: default build (A), narrow LSB-first
// build (B) and a three-slave build exercising an out-of-range select (C).
module tb_spi_mstr_param;

    logic clk = 1'b0;
    logic rst_cnt;
    always #5 clk = ~clk;

    logic        wrt_a, miso_a, sclk_a, mosi_a, busy_a, done_a;
    logic [15:0] cmd_a, rd_a;
    logic [0:0]  sel_a;
    logic [1:0]  ss_n_a;

    logic        wrt_b, miso_b, sclk_b, mosi_b, busy_b, done_b;
    logic [7:0]  cmd_b, rd_b;
    logic [1:0]  sel_b;
    logic [3:0]  ss_n_b;

    logic        wrt_c, miso_c, sclk_c, mosi_c, busy_c, done_c;
    logic [3:0]  cmd_c, rd_c;
    logic [1:0]  sel_c;
    logic [2:0]  ss_n_c;

    int checks = 0;
    int errors = 0;
    int n;

    spi_mstr_param u_a (
        .clk(clk), .rst_cnt(rst_cnt), .wrt(wrt_a), .cmd(cmd_a), .ss_sel(sel_a),
        .MISO(miso_a), .SS_n(ss_n_a), .SCLK(sclk_a), .MOSI(mosi_a),
        .busy(busy_a), .done(done_a), .rd_data(rd_a)
    );

    spi_mstr_param #(.DATA_W(8), .DIV_W(4), .NUM_SS(4), .MSB_FIRST(0)) u_b (
        .clk(clk), .rst_cnt(rst_cnt), .wrt(wrt_b), .cmd(cmd_b), .ss_sel(sel_b),
        .MISO(miso_b), .SS_n(ss_n_b), .SCLK(sclk_b), .MOSI(mosi_b),
        .busy(busy_b), .done(done_b), .rd_data(rd_b)
    );

    spi_mstr_param #(.DATA_W(4), .DIV_W(3), .NUM_SS(3), .MSB_FIRST(1)) u_c (
        .clk(clk), .rst_cnt(rst_cnt), .wrt(wrt_c), .cmd(cmd_c), .ss_sel(sel_c),
        .MISO(miso_c), .SS_n(ss_n_c), .SCLK(sclk_c), .MOSI(mosi_c),
        .busy(busy_c), .done(done_c), .rd_data(rd_c)
    );

    assign miso_b = mosi_b;
    assign miso_c = mosi_c;

    // Slave for A: returns slv_word MSB-first, captures MOSI on SCLK rise.
    logic        loop_a;
    logic [15:0] slv_word, slv_rx;
    logic [3:0]  slv_cnt;
    logic        slv_idle;
    assign slv_idle = &ss_n_a;
    assign miso_a   = loop_a ? mosi_a : slv_word[4'd15 - slv_cnt];

    always @(posedge sclk_a or posedge slv_idle) begin
        if (slv_idle) begin
            slv_cnt <= 4'd0;
        end else begin
            slv_cnt <= slv_cnt + 4'd1;
            slv_rx  <= {slv_rx[14:0], mosi_a};
        end
    end

    int fall_cnt_a = 0;
    always @(negedge sclk_a) fall_cnt_a <= fall_cnt_a + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transfer on A; optional extra wrt (cmd FFFF) before edge inj_edge.
    task automatic xfer_a(input logic [15:0] c, input logic [0:0] s, input logic [1:0] exp_ss,
                          input logic [15:0] prev_rd, input int inj_edge, output int edges);
        int f0;
        bit gap;
        @(negedge clk);
        cmd_a = c; sel_a = s; wrt_a = 1'b1;
        @(posedge clk); #1;
        wrt_a = 1'b0;
        chk("a_ss_n", {30'd0, ss_n_a}, {30'd0, exp_ss});
        chk("a_busy_start", {31'd0, busy_a}, 32'd1);
        chk("a_done_clr", {31'd0, done_a}, 32'd0);
        chk("a_rd_hold", {16'd0, rd_a}, {16'd0, prev_rd});
        f0 = fall_cnt_a; edges = 0; gap = 1'b0;
        while (done_a !== 1'b1 && edges < 2000) begin
            if (busy_a !== 1'b1 || ss_n_a !== exp_ss) gap = 1'b1;
            wrt_a = (edges + 1 == inj_edge);
            if (wrt_a) cmd_a = 16'hFFFF;
            @(posedge clk); edges++; #1;
        end
        chk("a_busy_cont", {31'd0, gap}, 32'd0);
        chk("a_sclk_falls", fall_cnt_a - f0, 32'd16);
        chk("a_done_edge", edges, 32'd521);
        chk("a_busy_end", {31'd0, busy_a}, 32'd0);
        wrt_a = 1'b0;
    endtask

    initial begin
        wrt_a = 1'b0; cmd_a = 16'h0000; sel_a = 1'b0; loop_a = 1'b1; slv_word = 16'h0000;
        wrt_b = 1'b0; cmd_b = 8'h00; sel_b = 2'd0;
        wrt_c = 1'b0; cmd_c = 4'h0; sel_c = 2'd0;
        rst_cnt = 1'b1;
        #12;
        chk("rst_ss_n_a", {30'd0, ss_n_a}, 32'h3);
        chk("rst_sclk_a", {31'd0, sclk_a}, 32'd1);
        chk("rst_mosi_a", {31'd0, mosi_a}, 32'd0);
        chk("rst_busy_a", {31'd0, busy_a}, 32'd0);
        chk("rst_done_a", {31'd0, done_a}, 32'd1);
        chk("rst_rd_a", {16'd0, rd_a}, 32'd0);
        chk("rst_ss_n_b", {28'd0, ss_n_b}, 32'hF);
        chk("rst_sclk_b", {31'd0, sclk_b}, 32'd1);
        chk("rst_done_b", {31'd0, done_b}, 32'd1);
        chk("rst_sclk_c", {31'd0, sclk_c}, 32'd1);
        @(negedge clk);
        rst_cnt = 1'b0;

        // Loopback, default build.
        xfer_a(16'hA5C3, 1'b0, 2'b10, 16'h0000, 0, n);
        chk("a_rd_loop", {16'd0, rd_a}, 32'h0000A5C3);

        // Slave returns 1234 while receiving BEEF on select 1.
        loop_a = 1'b0; slv_word = 16'h1234;
        xfer_a(16'hBEEF, 1'b1, 2'b01, 16'hA5C3, 0, n);
        chk("a_rd_slave", {16'd0, rd_a}, 32'h00001234);
        chk("a_slave_rx", {16'd0, slv_rx}, 32'h0000BEEF);

        // wrt while busy is ignored.
        loop_a = 1'b1;
        xfer_a(16'h0F0F, 1'b0, 2'b10, 16'h1234, 100, n);
        chk("a_rd_ignore", {16'd0, rd_a}, 32'h00000F0F);

        // Asynchronous reset in the middle of a transfer.
        @(negedge clk);
        cmd_a = 16'h3C3C; sel_a = 1'b0; wrt_a = 1'b1;
        @(posedge clk); #1;
        wrt_a = 1'b0;
        repeat (199) @(posedge clk);
        #2 rst_cnt = 1'b1;
        #1;
        chk("mid_rst_ss_n", {30'd0, ss_n_a}, 32'h3);
        chk("mid_rst_sclk", {31'd0, sclk_a}, 32'd1);
        chk("mid_rst_done", {31'd0, done_a}, 32'd1);
        chk("mid_rst_busy", {31'd0, busy_a}, 32'd0);
        chk("mid_rst_rd", {16'd0, rd_a}, 32'd0);
        @(negedge clk);
        rst_cnt = 1'b0;

        // Clean restart; wrt coincident with done is ignored, next clk accepted.
        xfer_a(16'h5555, 1'b0, 2'b10, 16'h0000, 521, n);
        chk("a_rd_after_rst", {16'd0, rd_a}, 32'h00005555);
        chk("a_done_hold", {31'd0, done_a}, 32'd1);
        xfer_a(16'h8001, 1'b1, 2'b01, 16'h5555, 0, n);
        chk("a_rd_b2b", {16'd0, rd_a}, 32'h00008001);

        // Narrow LSB-first build, select 3.
        @(negedge clk);
        cmd_b = 8'h01; sel_b = 2'd3; wrt_b = 1'b1;
        @(posedge clk); #1;
        wrt_b = 1'b0;
        chk("b_ss_n", {28'd0, ss_n_b}, 32'h7);
        chk("b_mosi_first", {31'd0, mosi_b}, 32'd1);
        chk("b_busy", {31'd0, busy_b}, 32'd1);
        n = 0;
        while (done_b !== 1'b1 && n < 1000) begin
            @(posedge clk); n++; #1;
            if (n == 6) chk("b_mosi_after_front", {31'd0, mosi_b}, 32'd1);
        end
        chk("b_done_edge", n, 32'd133);
        chk("b_rd", {24'd0, rd_b}, 32'h01);
        chk("b_ss_n_end", {28'd0, ss_n_b}, 32'hF);

        // Out-of-range select: dummy transfer with every select high.
        @(negedge clk);
        cmd_c = 4'hA; sel_c = 2'd3; wrt_c = 1'b1;
        @(posedge clk); #1;
        wrt_c = 1'b0;
        chk("c_ss_n", {29'd0, ss_n_c}, 32'h7);
        chk("c_busy", {31'd0, busy_c}, 32'd1);
        n = 0;
        while (done_c !== 1'b1 && n < 1000) begin
            @(posedge clk); n++; #1;
        end
        chk("c_done_edge", n, 32'd35);
        chk("c_rd", {28'd0, rd_c}, 32'hA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
